uart_rx_capture_fifo: RTL and testbench

//   Parametrised UART receiver with an output FIFO. It replaces the fixed
//   8N1, 53-clock-half-period serial monitor used in our benches.

---
 rtl/uart_rx_capture_fifo_if.sv | 11 +
 rtl/uart_rx_capture_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_capture_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_capture_fifo_if.sv
// Read-side handshake bundle of the UART capture FIFO (first-word-fall-through head).
interface uart_rx_capture_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_rx_capture_fifo.sv
// Parametrised UART receiver: synchronised line, start-glitch rejection, parity
// and stop checks, and a FWFT capture FIFO with sticky error/overflow flags.
module uart_rx_capture_fifo #(
    parameter int CLKS_PER_HALF_BIT = 53,
    parameter int DATA_BITS         = 8,
    parameter int PARITY            = 0,
    parameter int STOP_BITS         = 1,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                        clock,
    input  logic                        design_rstn,
    input  logic                        rx_in,
    input  logic                        rx_enable,
    uart_rx_capture_fifo_if.master      rd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow,
    input  logic                        err_clear
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int BIT_CLKS = 2 * CLKS_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic                 sync1, sync2, rx_prev;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 frame_bad;
    logic                 push_req;
    logic                 set_ferr, set_perr;
    logic                 fall, parity_bad, pop, full, do_push, ovf_set;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;

    always_ff @(posedge clock or negedge design_rstn) begin
        if (!design_rstn) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    always_comb begin
        fall       = rx_prev & ~sync2;
        parity_bad = (PARITY == 1) ? ~(^shreg ^ sync2) : (^shreg ^ sync2);
    end

    // The counter is reloaded with a full bit period at each sample so every
    // later sample lands on the bit midpoint established by the start bit.
    always_ff @(posedge clock or negedge design_rstn) begin
        if (!design_rstn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            frame_bad <= 1'b0;
            push_req  <= 1'b0;
            set_ferr  <= 1'b0;
            set_perr  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            set_ferr <= 1'b0;
            set_perr <= 1'b0;
            if (!rx_enable) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (fall) begin
                            state <= S_START;
                            busy  <= 1'b1;
                            cnt   <= CW'(CLKS_PER_HALF_BIT);
                        end
                    end
                    S_START: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (sync2) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            cnt       <= CW'(BIT_CLKS - 1);
                            bit_idx   <= '0;
                            frame_bad <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            shreg <= {sync2, shreg[DATA_BITS-1:1]};
                            cnt   <= CW'(BIT_CLKS - 1);
                            if (bit_idx == 4'(DATA_BITS - 1)) begin
                                state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                                stop_idx <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt   <= CW'(BIT_CLKS - 1);
                            state <= S_STOP;
                            if (parity_bad) begin
                                set_perr  <= 1'b1;
                                frame_bad <= 1'b1;
                            end
                        end
                    end
                    S_STOP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            set_ferr <= ~sync2;
                            if (stop_idx == 1'(STOP_BITS - 1)) begin
                                state    <= S_IDLE;
                                busy     <= 1'b0;
                                push_req <= ~frame_bad & sync2;
                            end else begin
                                stop_idx  <= 1'b1;
                                cnt       <= CW'(BIT_CLKS - 1);
                                frame_bad <= frame_bad | ~sync2;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pop     = rd.rd_valid & rd.rd_ready;
        full    = (count == (AW+1)'(FIFO_DEPTH));
        do_push = push_req & (~full | pop);
        ovf_set = push_req & full & ~pop;
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clock or negedge design_rstn) begin
        if (!design_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A flag-setting event in the same cycle as err_clear wins.
    always_ff @(posedge clock or negedge design_rstn) begin
        if (!design_rstn) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err  <= set_ferr | (frame_err  & ~err_clear);
            parity_err <= set_perr | (parity_err & ~err_clear);
            overflow   <= ovf_set  | (overflow   & ~err_clear);
        end
    end

    assign fifo_count  = count;
    assign rd.rd_valid = (count != '0);
    assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_uart_rx_capture_fifo.sv
// Directed bench for uart_rx_capture_fifo: four instances cover default 8N1,
// even parity, a depth-4 FIFO, and 9-bit data with two stop bits.
module tb_uart_rx_capture_fifo;
    logic       clock;
    logic       design_rstn;
    logic [3:0] rx_line;
    logic [3:0] rx_en;
    logic [3:0] err_clr;
    wire  [3:0] busy, ferr, perr, ovf;
    wire  [4:0] cnt_a, cnt_b, cnt_d;
    wire  [2:0] cnt_c;
    int         checks;
    int         failures;

    uart_rx_capture_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_rx_capture_fifo_if #(.DATA_BITS(8)) if_b ();
    uart_rx_capture_fifo_if #(.DATA_BITS(8)) if_c ();
    uart_rx_capture_fifo_if #(.DATA_BITS(9)) if_d ();

    uart_rx_capture_fifo dut_a (
        .clock(clock), .design_rstn(design_rstn), .rx_in(rx_line[0]), .rx_enable(rx_en[0]),
        .rd(if_a.master), .fifo_count(cnt_a), .busy(busy[0]), .frame_err(ferr[0]),
        .parity_err(perr[0]), .overflow(ovf[0]), .err_clear(err_clr[0])
    );

    uart_rx_capture_fifo #(.CLKS_PER_HALF_BIT(8), .PARITY(2)) dut_b (
        .clock(clock), .design_rstn(design_rstn), .rx_in(rx_line[1]), .rx_enable(rx_en[1]),
        .rd(if_b.master), .fifo_count(cnt_b), .busy(busy[1]), .frame_err(ferr[1]),
        .parity_err(perr[1]), .overflow(ovf[1]), .err_clear(err_clr[1])
    );

    uart_rx_capture_fifo #(.CLKS_PER_HALF_BIT(8), .FIFO_DEPTH(4)) dut_c (
        .clock(clock), .design_rstn(design_rstn), .rx_in(rx_line[2]), .rx_enable(rx_en[2]),
        .rd(if_c.master), .fifo_count(cnt_c), .busy(busy[2]), .frame_err(ferr[2]),
        .parity_err(perr[2]), .overflow(ovf[2]), .err_clear(err_clr[2])
    );

    uart_rx_capture_fifo #(.CLKS_PER_HALF_BIT(8), .DATA_BITS(9), .STOP_BITS(2)) dut_d (
        .clock(clock), .design_rstn(design_rstn), .rx_in(rx_line[3]), .rx_enable(rx_en[3]),
        .rd(if_d.master), .fifo_count(cnt_d), .busy(busy[3]), .frame_err(ferr[3]),
        .parity_err(perr[3]), .overflow(ovf[3]), .err_clear(err_clr[3])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Serialises one frame LSB first; pbit < 0 means no parity bit. With mid_check set
    // the last stop bit is split to probe rd_valid of instance A around its midpoint.
    task automatic apply_frame(input int idx, input logic [8:0] data, input int nd,
                               input int pbit, input int nstop, input logic stop_val,
                               input int bit_clks, input bit mid_check);
        logic [15:0] f;
        int          n;
        f = '1;
        n = 0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < nd; i++) begin
            f[n] = data[i];
            n++;
        end
        if (pbit >= 0) begin
            f[n] = pbit[0];
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            f[n] = stop_val;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            rx_line[idx] = f[i];
            if (mid_check && i == n - 1) begin
                repeat (bit_clks / 2) @(negedge clock);
                check_output("a_valid_before_stop_mid", {15'd0, if_a.rd_valid}, 16'd0);
                repeat (10) @(negedge clock);
                check_output("a_valid_after_stop_mid", {15'd0, if_a.rd_valid}, 16'd1);
                repeat (bit_clks - bit_clks / 2 - 10) @(negedge clock);
            end else begin
                repeat (bit_clks) @(negedge clock);
            end
        end
        rx_line[idx] = 1'b1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        design_rstn = 1'b0;
        rx_line     = 4'hF;
        rx_en       = 4'hF;
        err_clr     = 4'h0;
        if_a.rd_ready = 1'b0;
        if_b.rd_ready = 1'b0;
        if_c.rd_ready = 1'b0;
        if_d.rd_ready = 1'b0;
        repeat (3) @(negedge clock);

        check_output("rst_valid", {15'd0, if_a.rd_valid}, 16'd0);
        check_output("rst_data", {8'd0, if_a.rd_data}, 16'd0);
        check_output("rst_count", {11'd0, cnt_a}, 16'd0);
        check_output("rst_busy", {12'd0, busy}, 16'd0);
        check_output("rst_flags", {4'd0, ferr, perr, ovf}, 16'd0);
        design_rstn = 1'b1;
        repeat (5) @(negedge clock);

        // Default 8N1 'H' with the rd_valid latency probe around the stop midpoint.
        apply_frame(0, 9'h048, 8, -1, 1, 1'b1, 106, 1'b1);
        repeat (20) @(negedge clock);
        check_output("a_h_data", {8'd0, if_a.rd_data}, 16'h0048);
        check_output("a_h_count", {11'd0, cnt_a}, 16'd1);
        check_output("a_h_flags", {13'd0, ferr[0], perr[0], ovf[0]}, 16'd0);
        if_a.rd_ready = 1'b1;
        @(negedge clock);
        if_a.rd_ready = 1'b0;
        check_output("a_pop_count", {11'd0, cnt_a}, 16'd0);

        // 20-clock start glitch.
        rx_line[0] = 1'b0;
        repeat (20) @(negedge clock);
        rx_line[0] = 1'b1;
        check_output("a_glitch_busy_hi", {15'd0, busy[0]}, 16'd1);
        repeat (60) @(negedge clock);
        check_output("a_glitch_busy_lo", {15'd0, busy[0]}, 16'd0);
        check_output("a_glitch_count", {11'd0, cnt_a}, 16'd0);
        check_output("a_glitch_flags", {13'd0, ferr[0], perr[0], ovf[0]}, 16'd0);

        // 0x55 with its stop bit held low, then a one-cycle err_clear.
        apply_frame(0, 9'h055, 8, -1, 1, 1'b0, 106, 1'b0);
        repeat (20) @(negedge clock);
        check_output("a_ferr_set", {15'd0, ferr[0]}, 16'd1);
        check_output("a_ferr_count", {11'd0, cnt_a}, 16'd0);
        check_output("a_ferr_perr", {15'd0, perr[0]}, 16'd0);
        err_clr[0] = 1'b1;
        @(negedge clock);
        err_clr[0] = 1'b0;
        @(negedge clock);
        check_output("a_ferr_cleared", {15'd0, ferr[0]}, 16'd0);

        // Even parity, 0x03 has two ones so the correct parity bit is 0.
        apply_frame(1, 9'h003, 8, 1, 1, 1'b1, 16, 1'b0);
        repeat (10) @(negedge clock);
        check_output("b_perr_set", {15'd0, perr[1]}, 16'd1);
        check_output("b_perr_count", {11'd0, cnt_b}, 16'd0);
        apply_frame(1, 9'h003, 8, 0, 1, 1'b1, 16, 1'b0);
        repeat (10) @(negedge clock);
        check_output("b_good_count", {11'd0, cnt_b}, 16'd1);
        check_output("b_good_data", {8'd0, if_b.rd_data}, 16'h0003);
        check_output("b_good_ferr", {15'd0, ferr[1]}, 16'd0);

        // Five frames into a depth-4 FIFO with no reads.
        for (int k = 1; k <= 5; k++) begin
            apply_frame(2, 9'(k), 8, -1, 1, 1'b1, 16, 1'b0);
        end
        repeat (10) @(negedge clock);
        check_output("c_full_count", {13'd0, cnt_c}, 16'd4);
        check_output("c_overflow", {15'd0, ovf[2]}, 16'd1);
        for (int k = 1; k <= 4; k++) begin
            check_output("c_pop_data", {8'd0, if_c.rd_data}, 16'(k));
            if_c.rd_ready = 1'b1;
            @(negedge clock);
            if_c.rd_ready = 1'b0;
        end
        check_output("c_drained_count", {13'd0, cnt_c}, 16'd0);
        check_output("c_drained_valid", {15'd0, if_c.rd_valid}, 16'd0);

        // 9-bit data, two stop bits, back to back, then an aborted third frame.
        apply_frame(3, 9'h1A5, 9, -1, 2, 1'b1, 16, 1'b0);
        apply_frame(3, 9'h05A, 9, -1, 2, 1'b1, 16, 1'b0);
        rx_line[3] = 1'b0;
        repeat (80) @(negedge clock);
        check_output("d_abort_busy_hi", {15'd0, busy[3]}, 16'd1);
        rx_en[3] = 1'b0;
        @(negedge clock);
        rx_line[3] = 1'b1;
        repeat (3) @(negedge clock);
        check_output("d_abort_busy_lo", {15'd0, busy[3]}, 16'd0);
        rx_en[3] = 1'b1;
        repeat (200) @(negedge clock);
        check_output("d_count", {11'd0, cnt_d}, 16'd2);
        check_output("d_first", {7'd0, if_d.rd_data}, 16'h01A5);
        if_d.rd_ready = 1'b1;
        @(negedge clock);
        if_d.rd_ready = 1'b0;
        check_output("d_second", {7'd0, if_d.rd_data}, 16'h005A);
        check_output("d_flags", {13'd0, ferr[3], perr[3], ovf[3]}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
